// File: rtl/mini_audio_in_pkg.sv
// Shared types and constants for the stereo delta-sigma capture path.
package mini_audio_in_pkg;

  localparam int PCM_WIDTH = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic ONE   = 1'b1;
  localparam logic ZERO  = 1'b0;

  typedef struct packed {
    logic [PCM_WIDTH-1:0] r;
    logic [PCM_WIDTH-1:0] l;
  } pcm_word_t;

  // Width of a sinc2 datapath decimating by 2^decim_bits: log2(R^2) + 1.
  function automatic int cic_w(input int decim_bits);
    return 2 * decim_bits + 1;
  endfunction

endpackage

// File: rtl/cic2_decim.sv
// One channel: input synchronizer, 2nd-order CIC decimator and saturating scale to 16-bit PCM.
module cic2_decim
  import mini_audio_in_pkg::*;
#(
  parameter int DECIM_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 strobe,
  output logic [PCM_WIDTH-1:0] pcm,
  output logic                 pcm_valid
);

  localparam int W       = cic_w(DECIM_BITS);
  localparam int FS_BITS = 2 * DECIM_BITS;

  logic [1:0]           sync_q;
  logic                 x;
  logic [W-1:0]         i1, i2;
  logic [W-1:0]         c1, c2;
  logic [W-1:0]         d1, d2;
  logic                 strobe_d1, strobe_d2;
  logic [FS_BITS-1:0]   sat;
  logic [PCM_WIDTH-1:0] pcm_next;

  assign x = sync_q[1];

  // Integrators wrap freely; the comb differences cancel the wrap exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      i1        <= '0;
      i2        <= '0;
      c1        <= '0;
      c2        <= '0;
      d1        <= '0;
      d2        <= '0;
      strobe_d1 <= FALSE;
      strobe_d2 <= FALSE;
      pcm       <= '0;
      pcm_valid <= FALSE;
    end else begin
      sync_q    <= {sync_q[0], bit_in};
      i1        <= i1 + {{(W-1){ZERO}}, x};
      i2        <= i2 + i1;
      strobe_d1 <= strobe;
      strobe_d2 <= strobe_d1;
      pcm_valid <= strobe_d2;
      if (strobe) begin
        c1 <= i2 - d1;
        d1 <= i2;
      end
      if (strobe_d1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      if (strobe_d2) begin
        pcm <= pcm_next;
      end
    end
  end

  // Only exact full scale (R^2) sets the top bit; clamp it to all ones.
  assign sat = c2[W-1] ? '1 : c2[FS_BITS-1:0];

  generate
    if (FS_BITS >= PCM_WIDTH) begin : g_shr
      assign pcm_next = sat[FS_BITS-1 -: PCM_WIDTH];
    end else begin : g_shl
      assign pcm_next = {sat, {(PCM_WIDTH-FS_BITS){ZERO}}};
    end
  endgenerate

endmodule

// File: rtl/mini_audio_in_fifo.sv
// Synchronous word FIFO with registered empty/full flags and a one-cycle pull read.
module mini_audio_in_fifo
  import mini_audio_in_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  // Full is declared three entries early, leaving slack in the storage.
  localparam logic [CW-1:0]         MAX_ITEMS = CW'(DEPTH - 3);
  localparam logic [CW-1:0]         CNT_STEP  = CW'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_STEP  = DEPTH_BITS'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_next;
  logic                  push, pop;

  assign push = wr_en & ~full;
  assign pop  = rd_req & ~empty;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_STEP;
      2'b01:   count_next = count - CNT_STEP;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= TRUE;
      full     <= FALSE;
      rd_data  <= '0;
      rd_valid <= FALSE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_STEP;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_STEP;
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= pop;
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next >= MAX_ITEMS);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/mini_audio_in.sv
// Stereo 1-bit delta-sigma receiver: two sinc2 decimators feeding a PCM FIFO read by req/valid pull.
// Handshake: req_r pops one word when not empty; valid_r pulses the next cycle with data_r holding it.
module mini_audio_in
  import mini_audio_in_pkg::*;
#(
  parameter int DECIM_BITS         = 8,
  parameter int FIFO_DEPTH_IN_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_audio_r,
  input  logic        ext_audio_l,
  input  logic        req_r,
  output logic [31:0] data_r,
  output logic        valid_r,
  output logic        empty,
  output logic        overflow,
  input  logic        overflow_clear
);

  localparam logic [DECIM_BITS-1:0] DC_STEP     = DECIM_BITS'(1);
  localparam logic [1:0]            SETTLE_DONE = 2'd2;
  localparam logic [1:0]            SETTLE_STEP = 2'd1;

  logic [DECIM_BITS-1:0] dc;
  logic                  strobe;
  logic [1:0]            settle_cnt;
  logic                  settled_at_strobe;
  logic                  pcm_valid_r, pcm_valid_l;
  logic                  wr_en;
  logic                  full;
  pcm_word_t             word;

  assign strobe = (dc == {DECIM_BITS{ONE}});

  // The settle flag is captured at the strobe so it stays aligned with that
  // strobe's output, which emerges three cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      dc                <= '0;
      settle_cnt        <= '0;
      settled_at_strobe <= FALSE;
      overflow          <= FALSE;
    end else begin
      dc <= dc + DC_STEP;
      if (strobe) begin
        settled_at_strobe <= (settle_cnt == SETTLE_DONE);
        if (settle_cnt != SETTLE_DONE) begin
          settle_cnt <= settle_cnt + SETTLE_STEP;
        end
      end
      if (wr_en && full) begin
        overflow <= TRUE;
      end else if (overflow_clear) begin
        overflow <= FALSE;
      end
    end
  end

  cic2_decim #(.DECIM_BITS(DECIM_BITS)) u_cic_r (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (ext_audio_r),
    .strobe    (strobe),
    .pcm       (word.r),
    .pcm_valid (pcm_valid_r)
  );

  cic2_decim #(.DECIM_BITS(DECIM_BITS)) u_cic_l (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (ext_audio_l),
    .strobe    (strobe),
    .pcm       (word.l),
    .pcm_valid (pcm_valid_l)
  );

  assign wr_en = pcm_valid_r & pcm_valid_l & settled_at_strobe;

  mini_audio_in_fifo #(
    .WIDTH      (32),
    .DEPTH_BITS (FIFO_DEPTH_IN_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (word),
    .rd_req   (req_r),
    .rd_data  (data_r),
    .rd_valid (valid_r),
    .empty    (empty),
    .full     (full)
  );

endmodule

// File: tb/tb_mini_audio_in.sv
// Self-checking bench for mini_audio_in: a triangular-window sinc2 model plus a word-level FIFO scoreboard.
module tb_mini_audio_in;

  localparam int D         = 8;
  localparam int N         = 4;
  localparam int R         = 1 << D;
  localparam int MAX_ITEMS = (1 << N) - 3;
  localparam int HIST      = 65536;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ext_audio_r = 1'b0;
  logic        ext_audio_l = 1'b0;
  logic        req_r = 1'b0;
  logic        overflow_clear = 1'b0;
  logic [31:0] data_r;
  logic        valid_r;
  logic        empty;
  logic        overflow;

  mini_audio_in #(.DECIM_BITS(D), .FIFO_DEPTH_IN_BITS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .ext_audio_r    (ext_audio_r),
    .ext_audio_l    (ext_audio_l),
    .req_r          (req_r),
    .data_r         (data_r),
    .valid_r        (valid_r),
    .empty          (empty),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    int          due;
    logic [31:0] word;
  } pend_t;

  bit          hist_r [HIST];
  bit          hist_l [HIST];
  logic [31:0] exp_q[$];
  pend_t       pend_q[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data  = '0;
  logic        exp_ovf   = 1'b0;
  int          strobes   = 0;
  int          first_cyc = -1;
  int          pops      = 0;
  logic [31:0] last_data = '0;
  bit          mon_on    = 1'b0;

  // Synchronized bit seen by the filter in cycle k: the input two cycles earlier.
  function automatic int x_at(input int chan, input int k);
    if (k < 2) return 0;
    return chan != 0 ? int'(hist_l[k-2]) : int'(hist_r[k-2]);
  endfunction

  // sinc2 output for the strobe in cycle t: triangular weights over the last 2R samples.
  function automatic logic [15:0] ref_pcm(input int chan, input int t);
    longint acc;
    longint full_scale;
    int     w;
    acc = 0;
    full_scale = longint'(1) << (2 * D);
    for (int m = 1; m <= 2 * R; m++) begin
      w = (m <= R + 1) ? m - 1 : 2 * R + 1 - m;
      acc += longint'(w * x_at(chan, t - m));
    end
    if (acc >= full_scale) acc = full_scale - 1;
    if (2 * D >= 16) acc = acc >> (2 * D - 16);
    else acc = acc << (16 - 2 * D);
    return acc[15:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_q.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_ovf   = 1'b0;
    strobes   = 0;
    first_cyc = -1;
    cyc       = 0;
  endtask

  task automatic model_step();
    bit    full_now;
    bit    drop;
    pend_t p;
    hist_r[cyc] = ext_audio_r;
    hist_l[cyc] = ext_audio_l;
    full_now  = (exp_q.size() >= MAX_ITEMS);
    drop      = 1'b0;
    exp_valid = 1'b0;
    if (req_r && exp_q.size() > 0) begin
      exp_valid = 1'b1;
      exp_data  = exp_q.pop_front();
    end
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      p = pend_q.pop_front();
      if (full_now) drop = 1'b1;
      else exp_q.push_back(p.word);
    end
    if (drop) exp_ovf = 1'b1;
    else if (overflow_clear) exp_ovf = 1'b0;
    if (cyc % R == R - 1) begin
      strobes++;
      if (strobes >= 3) begin
        p.due  = cyc + 3;
        p.word = {ref_pcm(0, cyc), ref_pcm(1, cyc)};
        pend_q.push_back(p);
      end
    end
    cyc++;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("overflow", 32'(overflow), 32'(exp_ovf));
      check("valid_r", 32'(valid_r), 32'(exp_valid));
      if (exp_valid) check("data_r", data_r, exp_data);
      if (!reset && empty === 1'b0 && first_cyc < 0) first_cyc = cyc;
      if (valid_r === 1'b1) begin
        pops++;
        last_data = data_r;
      end
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- drivers ----------------
  int   in_mode = 0;
  int   req_mode = 0;
  int   req_pct = 50;
  int   p_r = 50;
  int   p_l = 50;
  logic clr_force = 1'b0;
  logic clr_rand = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    case (in_mode)
      0: begin ext_audio_r = 1'b0; ext_audio_l = 1'b0; end
      1: begin ext_audio_r = 1'b1; ext_audio_l = 1'b1; end
      2: begin ext_audio_r = 1'b1; ext_audio_l = ~ext_audio_l; end
      default: begin
        if (cyc % R == 0) begin
          p_r     = $urandom_range(0, 100);
          p_l     = $urandom_range(0, 100);
          req_pct = $urandom_range(0, 60);
        end
        ext_audio_r = ($urandom_range(0, 99) < p_r);
        ext_audio_l = ($urandom_range(0, 99) < p_l);
      end
    endcase
    case (req_mode)
      0:       req_r = 1'b0;
      1:       req_r = 1'b1;
      default: req_r = ($urandom_range(0, 99) < req_pct);
    endcase
    overflow_clear = clr_force | (clr_rand & ($urandom_range(0, 511) == 0));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit timed_out;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(negedge clk);
    check("reset_data_r", data_r, 32'h0);

    // Zeros, no reads: fill to full, then overflow; the last strobe's word lands on a full FIFO.
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(5129);
    @(negedge clk);
    check("ovf_after_fill", 32'(overflow), 32'h1);
    check("first_word_cycle", first_cyc, 771);
    pops = 0;
    req_mode = 1;
    run(20);
    req_mode = 0;
    clr_force = 1'b1;
    step();
    clr_force = 1'b0;
    step();
    @(negedge clk);
    check("pop_count", pops, 13);
    check("ovf_cleared", 32'(overflow), 32'h0);

    // Full-scale ones across many integrator wraps.
    in_mode = 1; req_mode = 2; req_pct = 50;
    run(40 * R);
    check("ones_word", last_data, 32'hFFFF_FFFF);

    // L toggling every cycle, R high.
    in_mode = 2;
    run(20 * R);
    check("alt_word", last_data, 32'hFFFF_8000);

    // Random densities, random reads and occasional clears.
    in_mode = 3; clr_rand = 1'b1;
    run(60 * R);

    // Fill to overflow, drain to exactly 5 words, then reset mid-stream.
    clr_rand = 1'b0; req_mode = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 30 * R; i++) begin
      step();
      if (exp_ovf) begin timed_out = 1'b0; break; end
    end
    check("fill_bound", 32'(timed_out), 32'h0);
    req_mode = 1;
    timed_out = 1'b1;
    for (int i = 0; i < 4 * R; i++) begin
      step();
      if (exp_q.size() <= 5) begin timed_out = 1'b0; break; end
    end
    check("drain_bound", 32'(timed_out), 32'h0);
    req_mode = 0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("pre_reset_ovf", 32'(overflow), 32'h1);
    check("pre_reset_empty", 32'(empty), 32'h0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_empty", 32'(empty), 32'h1);
    check("post_reset_valid", 32'(valid_r), 32'h0);
    check("post_reset_ovf", 32'(overflow), 32'h0);

    // Pop the single queued word in the very cycle the next one is written.
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (cyc == 1026) begin timed_out = 1'b0; break; end
    end
    check("wr_pop_bound", 32'(timed_out), 32'h0);
    req_r = 1'b1;
    step();
    @(negedge clk);
    check("wr_pop_empty", 32'(empty), 32'h0);
    check("wr_pop_valid", 32'(valid_r), 32'h1);
    check("first_word_after_reset", first_cyc, 771);

    req_mode = 2; req_pct = 40; clr_rand = 1'b1;
    run(10 * R);
    req_mode = 1; clr_rand = 1'b0;
    run(40);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
